// File: rtl/tank_pkg.sv
// ---------------------------------------------------------------------------
// tank_pkg
// Shared definitions for the tank movement command path.
//   dir_e      : 2-bit heading encoding consumed by the tank (direction[1:0])
//   state_e    : states of the tank_move_ctrl request FSM
//   COORD_W    : width of one grid coordinate
//   MAP_ADDR_W : width of the wall-map address {y, x}
//   map_addr_of: packs a grid cell into a wall-map address
// ---------------------------------------------------------------------------
package tank_pkg;

    localparam int unsigned COORD_W    = 4;
    localparam int unsigned MAP_ADDR_W = 2 * COORD_W;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    function automatic logic [MAP_ADDR_W-1:0] map_addr_of(
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/tank_target_calc.sv
// ---------------------------------------------------------------------------
// tank_target_calc
// Combinational neighbour-cell calculation for a requested move.
//   cmd_dir  in  2  heading of the requested move (dir_e encoding)
//   tank_x   in  4  current grid x
//   tank_y   in  4  current grid y
//   tx       out 4  target grid x
//   ty       out 4  target grid y
//   in_range out 1  target lies inside 0..GRID_MAX_X / 0..GRID_MAX_Y
// ---------------------------------------------------------------------------
module tank_target_calc
    import tank_pkg::*;
#(
    parameter int unsigned GRID_MAX_X = 15,
    parameter int unsigned GRID_MAX_Y = 15
) (
    input  logic [1:0]         cmd_dir,
    input  logic [COORD_W-1:0] tank_x,
    input  logic [COORD_W-1:0] tank_y,
    output logic [COORD_W-1:0] tx,
    output logic [COORD_W-1:0] ty,
    output logic               in_range
);

    always_comb begin
        tx       = tank_x;
        ty       = tank_y;
        in_range = 1'b1;
        case (cmd_dir)
            DIR_UP: begin
                ty       = tank_y - 1'b1;
                in_range = (tank_y != '0);
            end
            DIR_DOWN: begin
                ty       = tank_y + 1'b1;
                in_range = (32'(tank_y) < GRID_MAX_Y);
            end
            DIR_LEFT: begin
                tx       = tank_x - 1'b1;
                in_range = (tank_x != '0);
            end
            default: begin
                tx       = tank_x + 1'b1;
                in_range = (32'(tank_x) < GRID_MAX_X);
            end
        endcase
    end

endmodule

// File: rtl/tank_move_ctrl.sv
// ---------------------------------------------------------------------------
// tank_move_ctrl
// Turns debounced key levels into one move request per tank handshake,
// after bounds-checking the target cell and looking it up in the wall map.
//   clk, resetn                 clock, asynchronous active-low reset
//   key_up/down/left/right  in  key levels, priority up > down > left > right
//   tank_x, tank_y          in  current tank grid cell
//   tank_moving             in  tank busy flag
//   map_addr                out wall-map read address {y, x}
//   map_wall                in  wall bit, one cycle after map_addr
//   direction               out {move request, heading}
//   facing                  out last requested heading
//   blocked                 out one-cycle pulse on a refused move
//   ack_err                 out one-cycle pulse when the tank never acknowledged
// ---------------------------------------------------------------------------
module tank_move_ctrl
    import tank_pkg::*;
#(
    parameter int unsigned GRID_MAX_X   = 15,
    parameter int unsigned GRID_MAX_Y   = 15,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter logic [1:0]  RESET_FACING = 2'd0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic [COORD_W-1:0]    tank_x,
    input  logic [COORD_W-1:0]    tank_y,
    input  logic                  tank_moving,
    output logic [MAP_ADDR_W-1:0] map_addr,
    input  logic                  map_wall,
    output logic [2:0]            direction,
    output logic [1:0]            facing,
    output logic                  blocked,
    output logic                  ack_err
);

    localparam int unsigned  CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e                state_q, state_d;
    dir_e                  cmd_dir_q, cmd_dir_d;
    logic [1:0]            facing_q, facing_d;
    logic [MAP_ADDR_W-1:0] map_addr_q, map_addr_d;
    logic [2:0]            dir_q, dir_d;
    logic                  blocked_q, blocked_d;
    logic                  ack_err_q, ack_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  key_any;
    dir_e                  key_dir;
    logic [COORD_W-1:0]    tx, ty;
    logic                  in_range;

    always_comb begin
        key_any = key_up | key_down | key_left | key_right;
        key_dir = DIR_RIGHT;
        if (key_up)        key_dir = DIR_UP;
        else if (key_down) key_dir = DIR_DOWN;
        else if (key_left) key_dir = DIR_LEFT;
    end

    // Target is only consumed in IDLE, where the key choice is the heading
    // about to be latched, so the live key selection feeds the calculator.
    tank_target_calc #(
        .GRID_MAX_X (GRID_MAX_X),
        .GRID_MAX_Y (GRID_MAX_Y)
    ) u_target (
        .cmd_dir  (key_dir),
        .tank_x   (tank_x),
        .tank_y   (tank_y),
        .tx       (tx),
        .ty       (ty),
        .in_range (in_range)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cmd_dir_q  <= DIR_UP;
            facing_q   <= RESET_FACING;
            map_addr_q <= '0;
            dir_q      <= '0;
            blocked_q  <= 1'b0;
            ack_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_dir_q  <= cmd_dir_d;
            facing_q   <= facing_d;
            map_addr_q <= map_addr_d;
            dir_q      <= dir_d;
            blocked_q  <= blocked_d;
            ack_err_q  <= ack_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_dir_d  = cmd_dir_q;
        facing_d   = facing_q;
        map_addr_d = map_addr_q;
        dir_d      = dir_q;
        blocked_d  = 1'b0;
        ack_err_d  = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_any && !tank_moving) begin
                    cmd_dir_d = key_dir;
                    facing_d  = key_dir;
                    if (!in_range) begin
                        blocked_d = 1'b1;
                    end else begin
                        map_addr_d = map_addr_of(ty, tx);
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (map_wall) begin
                    blocked_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    dir_d   = {1'b1, cmd_dir_q};
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Acknowledge wins over a timeout landing on the same edge.
                if (tank_moving) begin
                    dir_d   = {1'b0, cmd_dir_q};
                    state_d = ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    ack_err_d = 1'b1;
                    dir_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!tank_moving) begin
                    dir_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                dir_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign map_addr  = map_addr_q;
    assign direction = dir_q;
    assign facing    = facing_q;
    assign blocked   = blocked_q;
    assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_tank_move_ctrl.sv
module tb_tank_move_ctrl;

    localparam int unsigned GMX = 15;
    localparam int unsigned GMY = 15;
    localparam int unsigned ACK = 16;
    localparam logic [1:0]  RF  = 2'd0;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       key_up, key_down, key_left, key_right;
    logic [3:0] tank_x, tank_y;
    logic       tank_moving;
    logic [7:0] map_addr;
    logic       map_wall = 1'b0;
    logic [2:0] direction;
    logic [1:0] facing;
    logic       blocked, ack_err;

    logic       wall_mem [256];
    logic [7:0] last_addr;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Wall map RAM: one cycle read latency.
    always @(posedge clk) map_wall <= wall_mem[map_addr];

    tank_move_ctrl #(
        .GRID_MAX_X   (GMX),
        .GRID_MAX_Y   (GMY),
        .ACK_TIMEOUT  (ACK),
        .RESET_FACING (RF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_left    (key_left),
        .key_right   (key_right),
        .tank_x      (tank_x),
        .tank_y      (tank_y),
        .tank_moving (tank_moving),
        .map_addr    (map_addr),
        .map_wall    (map_wall),
        .direction   (direction),
        .facing      (facing),
        .blocked     (blocked),
        .ack_err     (ack_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k = {up, down, left, right}
    task automatic set_keys(input logic [3:0] k);
        {key_up, key_down, key_left, key_right} = k;
    endtask

    function automatic logic [1:0] pick_dir(input logic [3:0] k);
        if (k[3]) return 2'd0;
        if (k[2]) return 2'd1;
        if (k[1]) return 2'd2;
        return 2'd3;
    endfunction

    // One full request from IDLE. ack_delay < 0 means the tank never answers.
    task automatic run_move(input logic [3:0] x, input logic [3:0] y, input logic [3:0] k,
                            input int ack_delay, input int busy);
        logic [1:0] d;
        int nx, ny;
        logic ok, w;
        logic [7:0] a;
        d  = pick_dir(k);
        nx = int'(x);
        ny = int'(y);
        case (d)
            2'd0: ny = ny - 1;
            2'd1: ny = ny + 1;
            2'd2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        ok = (nx >= 0) && (nx <= int'(GMX)) && (ny >= 0) && (ny <= int'(GMY));
        a  = {ny[3:0], nx[3:0]};

        tank_x = x;
        tank_y = y;
        tank_moving = 1'b0;
        set_keys(k);
        tick();
        chk("facing", {6'd0, facing}, {6'd0, d});
        if (!ok) begin
            chk("edge_blocked", {7'd0, blocked}, 8'd1);
            chk("edge_addr_kept", map_addr, last_addr);
            chk("edge_dir", {5'd0, direction}, 8'd0);
            set_keys(4'd0);
            tick();
            chk("edge_blocked_end", {7'd0, blocked}, 8'd0);
            chk("edge_dir_after", {5'd0, direction}, 8'd0);
            return;
        end
        last_addr = a;
        chk("lookup_addr", map_addr, a);
        chk("lookup_blocked", {7'd0, blocked}, 8'd0);
        chk("lookup_dir", {5'd0, direction}, 8'd0);
        w = wall_mem[a];

        set_keys(4'($urandom_range(1, 15)));
        tick();
        chk("check_dir", {5'd0, direction}, 8'd0);
        chk("facing_latched", {6'd0, facing}, {6'd0, d});
        set_keys(4'd0);
        tick();
        if (w) begin
            chk("wall_blocked", {7'd0, blocked}, 8'd1);
            chk("wall_dir", {5'd0, direction}, 8'd0);
            tick();
            chk("wall_blocked_end", {7'd0, blocked}, 8'd0);
            chk("wall_dir_after", {5'd0, direction}, 8'd0);
            return;
        end
        chk("issue_dir", {5'd0, direction}, {5'd0, 1'b1, d});
        chk("issue_blocked", {7'd0, blocked}, 8'd0);

        if (ack_delay < 0) begin
            for (int i = 1; i < int'(ACK); i++) begin
                tick();
                chk("to_hold_dir", {5'd0, direction}, {5'd0, 1'b1, d});
                chk("to_no_err", {7'd0, ack_err}, 8'd0);
            end
            tick();
            chk("to_ack_err", {7'd0, ack_err}, 8'd1);
            chk("to_dir_clear", {5'd0, direction}, 8'd0);
            tick();
            chk("to_ack_err_end", {7'd0, ack_err}, 8'd0);
            chk("to_dir_idle", {5'd0, direction}, 8'd0);
            return;
        end

        for (int i = 0; i < ack_delay; i++) begin
            tick();
            chk("ack_wait_dir", {5'd0, direction}, {5'd0, 1'b1, d});
        end
        tank_moving = 1'b1;
        tick();
        chk("wait_dir", {5'd0, direction}, {5'd0, 1'b0, d});
        chk("wait_no_err", {7'd0, ack_err}, 8'd0);
        for (int i = 0; i < busy; i++) begin
            tick();
            chk("busy_dir", {5'd0, direction}, {5'd0, 1'b0, d});
        end
        tank_moving = 1'b0;
        tick();
        chk("done_dir", {5'd0, direction}, 8'd0);
    endtask

    initial begin
        set_keys(4'd0);
        tank_x = 4'd0;
        tank_y = 4'd0;
        tank_moving = 1'b0;
        for (int i = 0; i < 256; i++) wall_mem[i] = 1'b0;
        last_addr = 8'h00;

        // Reset state
        #1 resetn = 1'b0;
        #2;
        chk("rst_dir", {5'd0, direction}, 8'd0);
        chk("rst_facing", {6'd0, facing}, {6'd0, RF});
        chk("rst_addr", map_addr, 8'h00);
        chk("rst_blocked", {7'd0, blocked}, 8'd0);
        chk("rst_ack_err", {7'd0, ack_err}, 8'd0);
        #20;
        @(negedge clk) resetn = 1'b1;
        tick();
        chk("idle_dir", {5'd0, direction}, 8'd0);

        // Held right key at (5,5): full handshake, then back-to-back request
        tank_x = 4'd5;
        tank_y = 4'd5;
        set_keys(4'b0001);
        tick();
        chk("t1_addr", map_addr, 8'h56);
        chk("t1_dir_a", {5'd0, direction}, 8'd0);
        tick();
        chk("t1_dir_b", {5'd0, direction}, 8'd0);
        tick();
        chk("t1_issue", {5'd0, direction}, 8'b111);
        tank_moving = 1'b1;
        tick();
        chk("t1_wait", {5'd0, direction}, 8'b011);
        tick();
        chk("t1_wait2", {5'd0, direction}, 8'b011);
        tank_moving = 1'b0;
        tank_x = 4'd6;
        tick();
        chk("t1_release", {5'd0, direction}, 8'd0);
        tick();
        chk("t1_addr2", map_addr, 8'h57);
        chk("t1_dir_c", {5'd0, direction}, 8'd0);
        tick();
        tick();
        chk("t1_issue2", {5'd0, direction}, 8'b111);
        tank_moving = 1'b1;
        set_keys(4'd0);
        tick();
        chk("t1_wait3", {5'd0, direction}, 8'b011);
        tank_moving = 1'b0;
        tick();
        chk("t1_end", {5'd0, direction}, 8'd0);
        last_addr = 8'h57;

        // Key pressed while the tank is still busy: no request
        tank_moving = 1'b1;
        tank_x = 4'd4;
        tank_y = 4'd4;
        set_keys(4'b0100);
        tick();
        tick();
        chk("busy_addr", map_addr, last_addr);
        chk("busy_facing", {6'd0, facing}, 8'd3);
        chk("busy_blocked", {7'd0, blocked}, 8'd0);
        tank_moving = 1'b0;
        set_keys(4'd0);
        tick();

        // Left edge: turn in place
        run_move(4'd0, 4'd3, 4'b0010, 0, 0);
        chk("t2_facing", {6'd0, facing}, 8'd2);
        // Other edges
        run_move(4'd15, 4'd9, 4'b0001, 0, 0);
        run_move(4'd9, 4'd0, 4'b1000, 0, 0);
        run_move(4'd9, 4'd15, 4'b0100, 0, 0);

        // Wall above (4,4)
        wall_mem[8'h34] = 1'b1;
        run_move(4'd4, 4'd4, 4'b1000, 0, 1);
        chk("t3_facing", {6'd0, facing}, 8'd0);
        wall_mem[8'h34] = 1'b0;

        // Up and right together: up wins
        run_move(4'd4, 4'd4, 4'b1001, 0, 1);
        // Priority even when the winner is refused
        run_move(4'd3, 4'd0, 4'b1001, 0, 0);

        // Acknowledge timeout, and latest legal acknowledge
        run_move(4'd7, 4'd7, 4'b0001, -1, 0);
        run_move(4'd7, 4'd7, 4'b0100, int'(ACK) - 1, 2);

        // Reset during WAIT
        tank_x = 4'd7;
        tank_y = 4'd7;
        set_keys(4'b0001);
        tick();
        set_keys(4'd0);
        tick();
        tick();
        tank_moving = 1'b1;
        tick();
        chk("t6_wait", {5'd0, direction}, 8'b011);
        #3 resetn = 1'b0;
        #1;
        chk("t6_dir", {5'd0, direction}, 8'd0);
        chk("t6_facing", {6'd0, facing}, {6'd0, RF});
        chk("t6_addr", map_addr, 8'h00);
        last_addr = 8'h00;
        tank_moving = 1'b0;
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_dir", {5'd0, direction}, 8'd0);
            chk("t6_idle_addr", map_addr, 8'h00);
        end
        run_move(4'd7, 4'd7, 4'b0001, 1, 0);

        // Randomized episodes
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rx, ry, rk;
            int ad;
            for (int i = 0; i < 256; i++) wall_mem[i] = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: rx = 4'd0;
                1: rx = 4'd15;
                default: rx = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 3))
                0: ry = 4'd0;
                1: ry = 4'd15;
                default: ry = 4'($urandom_range(0, 15));
            endcase
            rk = 4'($urandom_range(1, 15));
            ad = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, ACK - 1));
            run_move(rx, ry, rk, ad, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
